// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data-memory target with internal RAM and out-of-range flag
//   clk, reset        : clock, synchronous active-high reset
//   req, we, addr, wdata : request from the core, held until ack
//   ack, rdata, err   : registered one-cycle response
//   busy              : high while a request is in flight (WAIT/RESP)
//   rzero             : zero-load flag, present only with DMR_ZERO_FLAG_EN defined
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 200,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
`ifdef DMR_ZERO_FLAG_EN
  output logic                  rzero,
`endif
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  if (WAIT_CYCLES > 15 || WAIT_CYCLES < 0) begin : g_wait_chk
    $error("WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH > 2 ** ADDR_WIDTH) begin : g_depth_chk
    $error("DEPTH exceeds address space");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rzero_q;
  logic                  in_rng_q;
  logic                  idle_go;
  logic                  enter_resp;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_word;
  assign in_rng_q = {1'b0, addr_q} < DEPTH_W;
  assign rd_word  = in_rng_q ? mem[addr_q] : '0;
  // The store commits on the edge that enters RESP; with zero wait states that
  // edge is also the acceptance edge, so the live inputs are the source.
  always_comb begin
    idle_go    = state_q == IDLE && req;
    enter_resp = (idle_go && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
    wr_addr    = state_q == IDLE ? addr : addr_q;
    wr_data    = state_q == IDLE ? wdata : wdata_q;
    wr_en      = !reset && enter_resp && (state_q == IDLE ? we : we_q) && ({1'b0, wr_addr} < DEPTH_W);
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rzero_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rzero_q <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          addr_q  <= addr;
          we_q    <= we;
          wdata_q <= wdata;
          cnt_q   <= CNT_INIT;
          state_q <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          state_q <= cnt_q == 4'd0 ? RESP : WAIT;
          cnt_q   <= cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        end
        RESP: begin
          ack_q   <= 1'b1;
          err_q   <= !in_rng_q;
          rdata_q <= we_q ? '0 : rd_word;
          rzero_q <= !we_q && in_rng_q && rd_word == '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = state_q != IDLE;
`ifdef DMR_ZERO_FLAG_EN
  assign rzero = rzero_q;
`else
  logic unused_rzero;
  assign unused_rzero = rzero_q;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (WAIT_CYCLES=2 and 0)
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset, req, we, ack, err, busy;
  logic [7:0] addr;
  logic [31:0] wdata, rdata;
  logic req0, we0, ack0, err0, busy0;
  logic [7:0] addr0;
  logic [31:0] wdata0, rdata0;
`ifdef DMR_ZERO_FLAG_EN
  logic rzero, rzero0;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [33:0] sb [$];
  always #5 clk = ~clk;
  data_mem_responder dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err),
`ifdef DMR_ZERO_FLAG_EN
    .rzero(rzero),
`endif
    .busy(busy)
  );
  data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .err(err0),
`ifdef DMR_ZERO_FLAG_EN
    .rzero(rzero0),
`endif
    .busy(busy0)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic e, input logic [31:0] r);
    req = 1'b1; we = w; addr = a; wdata = d;
    sb.push_back({!w && !e && r == 32'h0, e, r});
  endtask
  // k counts edges from the acceptance edge up to the one that raises ack
  task automatic wait_ack(input int lat);
    int k = 0;
    do begin
      @(posedge clk); #1; k++;
      if (!ack) chk("busy_wait", busy, 1);
    end while (!ack && k < 12);
    chk("latency", k, lat);
    chk("busy_ack", busy, 0);
  endtask
  task automatic xact(input logic w, input logic [7:0] a, input logic [31:0] d, input logic e, input logic [31:0] r);
    @(negedge clk);
    issue(w, a, d, e, r);
    wait_ack(4);
    req = 1'b0;
  endtask
  task automatic xact0(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [31:0] r, input logic z);
    int k = 0;
    @(negedge clk);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    do begin
      @(posedge clk); #1; k++;
    end while (!ack0 && k < 8);
    req0 = 1'b0;
    chk("lat0", k, 2);
    chk("err0", err0, 0);
    chk("busy0", busy0, 0);
    if (!w) chk("rdata0", rdata0, r);
`ifdef DMR_ZERO_FLAG_EN
    chk("rzero0", rzero0, z);
`else
    if (z && w) chk("z_unused", 0, 1);
`endif
  endtask
  always @(negedge clk) begin
    logic [33:0] e;
    if (ack === 1'b1) begin
      if (sb.size() == 0) chk("spurious_ack", 1, 0);
      else begin
        e = sb.pop_front();
        chk("err", err, e[32]);
        chk("rdata", rdata, e[31:0]);
`ifdef DMR_ZERO_FLAG_EN
        chk("rzero", rzero, e[33]);
`endif
      end
    end
  end
  initial begin
    reset = 1'b1; req = 1'b1; we = 1'b1; addr = 8'h30; wdata = 32'hFFFF_FFFF;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h0; wdata0 = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
    end
    reset = 1'b0; req = 1'b0;
    xact(1, 8'h05, 32'hDEADBEEF, 0, 32'h0);
    xact(0, 8'h05, 32'h0, 0, 32'hDEADBEEF);
    xact(0, 8'h30, 32'h0, 0, 32'h0);
    xact(1, 8'd200, 32'h1, 1, 32'h0);
    xact(0, 8'd200, 32'h0, 1, 32'h0);
    xact(0, 8'd255, 32'h0, 1, 32'h0);
    xact(0, 8'd199, 32'h0, 0, 32'h0);
    xact(1, 8'h01, 32'h11, 0, 32'h0);
    xact(1, 8'h02, 32'h22, 0, 32'h0);
    @(negedge clk);
    issue(0, 8'h01, 32'h0, 0, 32'h11);
    wait_ack(4);
    issue(0, 8'h02, 32'h0, 0, 32'h22);
    wait_ack(4);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    reset = 1'b1; req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_ack", ack, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy_after", busy, 0);
    xact(0, 8'h10, 32'h0, 0, 32'h0);
    xact0(1, 8'h04, 32'h22, 32'h0, 0);
    xact0(0, 8'h03, 32'h0, 32'h0, 1);
    xact0(0, 8'h04, 32'h0, 32'h22, 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
